// File: rtl/alu_issue_stage_pkg.sv
// rtl/alu_issue_stage_pkg.sv - ALU function codes shared by the issue stage and the ALU.
// Config macro ALU_ISSUE_FWD_EN (writeback forwarding) is consumed by the files importing this.
package alu_issue_stage_pkg;

  localparam int ALU_FW = 4;

  typedef enum logic [ALU_FW-1:0] {
    ALU_NOTHING = 4'd0,
    ALU_ADD     = 4'd1,
    ALU_SUB     = 4'd2,
    ALU_AND     = 4'd3,
    ALU_OR      = 4'd4,
    ALU_XOR     = 4'd5,
    ALU_NOR     = 4'd6,
    ALU_SLT     = 4'd7,
    ALU_SLTU    = 4'd8,
    ALU_SLL     = 4'd9,
    ALU_SRL     = 4'd10,
    ALU_SRA     = 4'd11,
    ALU_LUI     = 4'd12
  } alu_fn_e;

endpackage

// File: rtl/alu_issue_entry.sv
// rtl/alu_issue_entry.sv - one issue payload register with writeback forwarding compare.
// Forwarding compare and stored indices exist only when ALU_ISSUE_FWD_EN is defined.
module alu_issue_entry
  import alu_issue_stage_pkg::*;
#(
  parameter int DW = 32,
  parameter int FW = ALU_FW,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  input  logic [FW-1:0] i_fn,
`ifdef ALU_ISSUE_FWD_EN
  input  logic [RW-1:0] i_rs_idx,
  input  logic [RW-1:0] i_rt_idx,
  input  logic          i_b_is_reg,
  input  logic          i_wb_valid,
  input  logic [RW-1:0] i_wb_idx,
  input  logic [DW-1:0] i_wb_data,
  output logic [RW-1:0] o_rs_idx,
  output logic [RW-1:0] o_rt_idx,
  output logic          o_b_is_reg,
`endif
  output logic [DW-1:0] o_a,
  output logic [DW-1:0] o_b,
  output logic [FW-1:0] o_fn
);

  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic [FW-1:0] r_fn;

`ifdef ALU_ISSUE_FWD_EN
  logic [RW-1:0] r_rs_idx;
  logic [RW-1:0] r_rt_idx;
  logic          r_b_is_reg;
  logic [RW-1:0] w_rs_idx;
  logic [RW-1:0] w_rt_idx;
  logic          w_b_is_reg;
  logic [DW-1:0] w_a;
  logic [DW-1:0] w_b;
  logic          w_wb_live;

  // The same compare serves both a fresh capture and a held value.
  always_comb begin
    w_rs_idx   = i_load ? i_rs_idx   : r_rs_idx;
    w_rt_idx   = i_load ? i_rt_idx   : r_rt_idx;
    w_b_is_reg = i_load ? i_b_is_reg : r_b_is_reg;
    w_a        = i_load ? i_a        : r_a;
    w_b        = i_load ? i_b        : r_b;
    w_wb_live  = i_wb_valid && (i_wb_idx != '0);
    if (w_wb_live && (i_wb_idx == w_rs_idx)) w_a = i_wb_data;
    if (w_wb_live && w_b_is_reg && (i_wb_idx == w_rt_idx)) w_b = i_wb_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_fn       <= FW'(ALU_NOTHING);
      r_rs_idx   <= '0;
      r_rt_idx   <= '0;
      r_b_is_reg <= 1'b0;
    end else begin
      r_a        <= w_a;
      r_b        <= w_b;
      r_rs_idx   <= w_rs_idx;
      r_rt_idx   <= w_rt_idx;
      r_b_is_reg <= w_b_is_reg;
      if (i_load) r_fn <= i_fn;
    end
  end

  assign o_rs_idx   = r_rs_idx;
  assign o_rt_idx   = r_rt_idx;
  assign o_b_is_reg = r_b_is_reg;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a  <= '0;
      r_b  <= '0;
      r_fn <= FW'(ALU_NOTHING);
    end else if (i_load) begin
      r_a  <= i_a;
      r_b  <= i_b;
      r_fn <= i_fn;
    end
  end
`endif

  assign o_a  = r_a;
  assign o_b  = r_b;
  assign o_fn = r_fn;

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ALU issue register with a 2-entry skid buffer and operand build.
// Optional writeback forwarding into held operands: define ALU_ISSUE_FWD_EN.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int DW = 32,
  parameter int FW = ALU_FW,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_rs_val,
  input  logic [DW-1:0] in_rt_val,
  input  logic [RW-1:0] in_rs_idx,
  input  logic [RW-1:0] in_rt_idx,
  input  logic [15:0]   in_imm,
  input  logic          in_imm_sel,
  input  logic          in_imm_signed,
  input  logic [FW-1:0] in_alu_function,
  input  logic          wb_valid,
  input  logic [RW-1:0] wb_idx,
  input  logic [DW-1:0] wb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] a_in,
  output logic [DW-1:0] b_in,
  output logic [FW-1:0] alu_function
);

  logic          r_out_valid;
  logic          r_skid_valid;
  logic          w_accept;
  logic          w_out_open;
  logic          w_out_load;
  logic          w_skid_load;
  logic [DW-1:0] w_imm_ext;
  logic [DW-1:0] w_new_b;
  logic [DW-1:0] w_skid_a;
  logic [DW-1:0] w_skid_b;
  logic [FW-1:0] w_skid_fn;

  assign w_accept    = in_valid && in_ready;
  assign w_out_open  = !r_out_valid || out_ready;
  assign w_out_load  = w_out_open && (r_skid_valid || w_accept);
  assign w_skid_load = w_accept && !w_out_open;

  assign w_imm_ext = {{(DW-16){in_imm_signed & in_imm[15]}}, in_imm};
  assign w_new_b   = in_imm_sel ? w_imm_ext : in_rt_val;

  // The skid only fills while the output register is stalled, so it always drains first.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      if (w_out_open) r_out_valid <= r_skid_valid || w_accept;
      if (w_out_open) r_skid_valid <= 1'b0;
      else if (w_accept) r_skid_valid <= 1'b1;
    end
  end

  assign in_ready  = !r_skid_valid;
  assign out_valid = r_out_valid;

`ifdef ALU_ISSUE_FWD_EN
  logic [RW-1:0] w_skid_rs_idx;
  logic [RW-1:0] w_skid_rt_idx;
  logic          w_skid_b_is_reg;
  logic [RW-1:0] w_unused_out_rs_idx;
  logic [RW-1:0] w_unused_out_rt_idx;
  logic          w_unused_out_b_is_reg;
`else
  logic w_unused;
  assign w_unused = ^{in_rs_idx, in_rt_idx, wb_valid, wb_idx, wb_data};
`endif

  alu_issue_entry #(.DW(DW), .FW(FW), .RW(RW)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_skid_load),
    .i_a        (in_rs_val),
    .i_b        (w_new_b),
    .i_fn       (in_alu_function),
`ifdef ALU_ISSUE_FWD_EN
    .i_rs_idx   (in_rs_idx),
    .i_rt_idx   (in_rt_idx),
    .i_b_is_reg (!in_imm_sel),
    .i_wb_valid (wb_valid),
    .i_wb_idx   (wb_idx),
    .i_wb_data  (wb_data),
    .o_rs_idx   (w_skid_rs_idx),
    .o_rt_idx   (w_skid_rt_idx),
    .o_b_is_reg (w_skid_b_is_reg),
`endif
    .o_a        (w_skid_a),
    .o_b        (w_skid_b),
    .o_fn       (w_skid_fn)
  );

  alu_issue_entry #(.DW(DW), .FW(FW), .RW(RW)) u_out (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_out_load),
    .i_a        (r_skid_valid ? w_skid_a  : in_rs_val),
    .i_b        (r_skid_valid ? w_skid_b  : w_new_b),
    .i_fn       (r_skid_valid ? w_skid_fn : in_alu_function),
`ifdef ALU_ISSUE_FWD_EN
    .i_rs_idx   (r_skid_valid ? w_skid_rs_idx   : in_rs_idx),
    .i_rt_idx   (r_skid_valid ? w_skid_rt_idx   : in_rt_idx),
    .i_b_is_reg (r_skid_valid ? w_skid_b_is_reg : !in_imm_sel),
    .i_wb_valid (wb_valid),
    .i_wb_idx   (wb_idx),
    .i_wb_data  (wb_data),
    .o_rs_idx   (w_unused_out_rs_idx),
    .o_rt_idx   (w_unused_out_rt_idx),
    .o_b_is_reg (w_unused_out_b_is_reg),
`endif
    .o_a        (a_in),
    .o_b        (b_in),
    .o_fn       (alu_function)
  );

endmodule
